// File: rtl/register_pipe_en.sv
// register_pipe_en: DEPTH-stage elastic pipeline register, WIDTH bits, valid/ready at both ends.
// Latency: DEPTH cycles from in_fire to out_valid on an empty pipe; 1 word/cycle throughput.
// Backpressure: combinational ready chain from out_ready to in_ready; bubbles collapse while stalled.
//
// Ports:
//   clk, rst (async active-high), flush (sync clear of all entries)
//   in_valid / in_data / in_ready    : upstream handshake
//   out_valid / out_data / out_ready : downstream handshake (last stage)
//   occupancy                        : registered count of entries held
//
// Optional feature macro REGISTER_PIPE_SKID_EN: adds an input skid register so in_ready
// becomes a flop, breaking the out_ready -> in_ready path; capacity grows to DEPTH+1.

module register_pipe_en #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0]            occ_q, occ_d;
    logic                        in_fire, out_fire;
    logic                        s0_vld;
    logic [WIDTH-1:0]            s0_dat;

    // A stage may take a new word when it is empty or when its own word moves on
    // this cycle. Walking the chain from the output back to the input lets a word
    // slide into an empty successor even while the output stage is stalled.
    always_comb begin
        logic go;
        ld = '0;
        go = out_ready || !v_q[DEPTH-1];
        ld[DEPTH-1] = go;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            go    = go || !v_q[i];
            ld[i] = go;
        end
    end

    assign out_fire  = v_q[DEPTH-1] && out_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef REGISTER_PIPE_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             in_rdy_q, in_rdy_d;

    // in_ready comes from a flop; flush and rst still gate it so no word is taken
    // in a flush cycle or while reset is held.
    assign in_ready = in_rdy_q && !flush && !rst;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        // The skid word is older than anything on in_data, so it feeds stage 0 first.
        s0_vld     = skid_vld_q || in_fire;
        s0_dat     = skid_vld_q ? skid_dat_q : in_data;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            skid_vld_d = !ld[0];
        end else begin
            skid_vld_d = in_fire && !ld[0];
        end
        if (!skid_vld_q && in_fire && !ld[0]) begin
            skid_dat_d = in_data;
        end
        in_rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_dat_q <= skid_dat_d;
    end
`else
    assign in_ready = ld[0] && !flush && !rst;
    assign in_fire  = in_valid && in_ready;
    assign s0_vld   = in_fire;
    assign s0_dat   = in_data;
`endif

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (ld[0]) begin
            v_d[0] = s0_vld;
            d_d[0] = s0_dat;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (ld[i]) begin
                v_d[i] = v_q[i-1];
                d_d[i] = d_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
        end
        occ_d = flush ? '0 : occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    // Only the output stage data is reset so out_data reads 0 during reset;
    // inner stage data is qualified by its valid bit and needs no reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] dat_q;
        if (i == DEPTH - 1) begin : g_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat_q <= '0;
                end else begin
                    dat_q <= d_d[i];
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                dat_q <= d_d[i];
            end
        end
        assign d_q[i] = dat_q;
    end

endmodule
